rsa_operand_loader: RTL and testbench

Upstream staging buffer for the Montgomery modular-exponentiation core (MonPro). It accepts the modulus n, ciphertext m and private exponent e as a stream of 64-bit word triplets, least-significant word first, up to 4096 bits. It stores them in three word-addressed buffers and computes the exponent bit length. It then pulses a start to the core, serves operand words to the core through a synchronous read port, and holds off new input until the core reports completion.

---
 rtl/rsa_operand_loader.sv | 238 +++++++++++++++++++++++
 tb/tb_rsa_operand_loader.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_operand_loader.sv
`timescale 1ns/1ps
// rsa_operand_loader
// Staging buffer in front of the Montgomery exponentiation core. Collects
// (n, m, e) word triplets least-significant word first, tracks the exponent
// bit length, starts the core, serves operand words through a registered
// read port and blocks new input until the core reports done.
//
// Optional feature macro: RSA_LOADER_ZERO_FILL_EN
//   defined   -> after a short load the unused upper words are zeroed
//                (FILL state) before the core is started.
//   undefined -> the core is started right after the last accepted word;
//                words above word_count keep stale data.
//
// Ports:
//   clk, reset             clock, asynchronous active-low reset
//   in_valid/in_ready      triplet handshake (in_ready is a state decode)
//   in_last                marks the most-significant triplet
//   n_in, m_in, e_in       operand words
//   core_start             one-cycle start pulse to the core
//   core_done              one-cycle completion pulse from the core
//   rd_addr                core read address
//   n_rd, m_rd, e_rd       read data, one-cycle latency
//   word_count             words loaded in the last completed load
//   e_bits                 exponent bit length of the last completed load
//   busy                   high outside IDLE
//   err_zero_exp           one-cycle pulse when a load had an all-zero exponent
module rsa_operand_loader #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
  input  logic [DATA_WIDTH-1:0] n_in,
  input  logic [DATA_WIDTH-1:0] m_in,
  input  logic [DATA_WIDTH-1:0] e_in,
  output logic                  core_start,
  input  logic                  core_done,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] n_rd,
  output logic [DATA_WIDTH-1:0] m_rd,
  output logic [DATA_WIDTH-1:0] e_rd,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic [ADDR_WIDTH+6:0] e_bits,
  output logic                  busy,
  output logic                  err_zero_exp
);

  localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;
  localparam int unsigned CNT_W  = ADDR_WIDTH + 1;
  localparam int unsigned BITS_W = ADDR_WIDTH + 7;
  localparam int unsigned POS_W  = $clog2(DATA_WIDTH);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_FILL  = 3'd2,
    S_START = 3'd3,
    S_WAIT  = 3'd4
  } state_t;

  state_t state_q;
  state_t state_d;

  // Operand buffers; contents intentionally survive reset.
  logic [DATA_WIDTH-1:0] n_mem [DEPTH];
  logic [DATA_WIDTH-1:0] m_mem [DEPTH];
  logic [DATA_WIDTH-1:0] e_mem [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                  accept;
  logic                  load_end;
  logic                  fill_we;
  logic                  mem_we;
  state_t                end_state;

  // Exponent tracking: highest nonzero e word and its top bit position.
  logic                  seen_q;
  logic [ADDR_WIDTH-1:0] top_word_q;
  logic [POS_W-1:0]      top_pos_q;
  logic                  e_nz;
  logic [POS_W-1:0]      e_msb;
  logic                  seen_n;
  logic [ADDR_WIDTH-1:0] top_word_n;
  logic [POS_W-1:0]      top_pos_n;
  logic [BITS_W-1:0]     e_bits_n;

  // Index of the highest set bit (0 when v is zero; qualified by e_nz).
  function automatic logic [POS_W-1:0] msb_index(input logic [DATA_WIDTH-1:0] v);
    logic [POS_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      if (v[i]) idx = POS_W'(i);
    end
    return idx;
  endfunction

  // Datapath decode of the current handshake.
  always_comb begin
    accept     = in_valid & in_ready;
    // A new load always starts at address 0, whatever wr_ptr holds.
    wr_addr    = (state_q == S_IDLE) ? '0 : wr_ptr_q;
    load_end   = accept & (in_last | (wr_addr == LAST_ADDR));
    e_nz       = |e_in;
    e_msb      = msb_index(e_in);
    // Tracking is restarted by the first accept of a load.
    seen_n     = e_nz | ((state_q != S_IDLE) & seen_q);
    top_word_n = e_nz ? wr_addr : top_word_q;
    top_pos_n  = e_nz ? e_msb : top_pos_q;
    e_bits_n   = seen_n ? (BITS_W'(top_word_n) * BITS_W'(DATA_WIDTH)
                           + BITS_W'(top_pos_n) + BITS_W'(1))
                        : '0;
`ifdef RSA_LOADER_ZERO_FILL_EN
    end_state  = (wr_addr != LAST_ADDR) ? S_FILL : S_START;
`else
    end_state  = S_START;
`endif
    mem_we     = accept | fill_we;
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = load_end ? end_state : S_LOAD;
      end
      S_LOAD: begin
        if (load_end) state_d = end_state;
      end
`ifdef RSA_LOADER_ZERO_FILL_EN
      S_FILL: begin
        if (wr_ptr_q == LAST_ADDR) state_d = S_START;
      end
`endif
      S_START: begin
        state_d = (e_bits != '0) ? S_WAIT : S_IDLE;
      end
      S_WAIT: begin
        if (core_done) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode.
  always_comb begin
    in_ready     = 1'b0;
    busy         = 1'b1;
    core_start   = 1'b0;
    err_zero_exp = 1'b0;
    fill_we      = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      S_LOAD: begin
        in_ready = 1'b1;
      end
      S_FILL: begin
        fill_we = 1'b1;
      end
      S_START: begin
        core_start   = (e_bits != '0);
        err_zero_exp = (e_bits == '0);
      end
      default: begin
      end
    endcase
  end

  // Write pointer, load results and exponent tracking.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      word_count <= '0;
      e_bits     <= '0;
      seen_q     <= 1'b0;
      top_word_q <= '0;
      top_pos_q  <= '0;
    end else begin
      if (accept) begin
        wr_ptr_q   <= wr_addr + ADDR_WIDTH'(1);
        seen_q     <= seen_n;
        top_word_q <= top_word_n;
        top_pos_q  <= top_pos_n;
        // Previous result is held until the next load actually begins.
        if (state_q == S_IDLE) e_bits <= '0;
        if (load_end) begin
          word_count <= CNT_W'(wr_addr) + CNT_W'(1);
          e_bits     <= e_bits_n;
        end
      end else if (fill_we) begin
        wr_ptr_q <= wr_ptr_q + ADDR_WIDTH'(1);
      end
    end
  end

  // Buffer writes: accepted triplets, or zeros while filling.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      n_mem[wr_addr] <= fill_we ? '0 : n_in;
      m_mem[wr_addr] <= fill_we ? '0 : m_in;
      e_mem[wr_addr] <= fill_we ? '0 : e_in;
    end
  end

  // Free-running registered read port (read-before-write on collisions).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      n_rd <= '0;
      m_rd <= '0;
      e_rd <= '0;
    end else begin
      n_rd <= n_mem[rd_addr];
      m_rd <= m_mem[rd_addr];
      e_rd <= e_mem[rd_addr];
    end
  end

endmodule

// File: tb/tb_rsa_operand_loader.sv
`timescale 1ns/1ps
// Directed bench for rsa_operand_loader with a word-array reference model.
module tb_rsa_operand_loader;

`ifdef RSA_LOADER_ZERO_FILL_EN
  localparam bit FILL_EN = 1'b1;
`else
  localparam bit FILL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic [63:0] n_in, m_in, e_in;
  logic        core_start;
  logic        core_done;
  logic [5:0]  rd_addr;
  logic [63:0] n_rd, m_rd, e_rd;
  logic [6:0]  word_count;
  logic [12:0] e_bits;
  logic        busy;
  logic        err_zero_exp;

  rsa_operand_loader #(.DATA_WIDTH(64), .ADDR_WIDTH(6)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .n_in(n_in), .m_in(m_in), .e_in(e_in),
    .core_start(core_start), .core_done(core_done),
    .rd_addr(rd_addr), .n_rd(n_rd), .m_rd(m_rd), .e_rd(e_rd),
    .word_count(word_count), .e_bits(e_bits),
    .busy(busy), .err_zero_exp(err_zero_exp)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_chk  = 0;

  // Stimulus words and the model's view of the three buffers.
  logic [63:0] s_n [64];
  logic [63:0] s_m [64];
  logic [63:0] s_e [64];
  logic [63:0] mdl_n [64];
  logic [63:0] mdl_m [64];
  logic [63:0] mdl_e [64];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    check(name, 64'(act), 64'(exp));
  endtask

  // Exponent bit length from the loaded e words: highest set bit overall + 1.
  function automatic int exp_bits(input int nw);
    for (int w = nw - 1; w >= 0; w--) begin
      logic [63:0] v;
      v = mdl_e[w];
      for (int b = 63; b >= 0; b--) begin
        if (v[b]) return w * 64 + b + 1;
      end
    end
    return 0;
  endfunction

  // Cycles from last accept to core_start.
  function automatic int lat(input int nw);
    return (FILL_EN && nw < 64) ? (65 - nw) : 1;
  endfunction

  // Read-port scoreboard: data one cycle after the address must match the model.
  bit         chk_rd = 1'b0;
  logic       rd_v   = 1'b0;
  logic [5:0] rd_a_q = '0;
  always @(posedge clk) begin
    rd_v   <= chk_rd && (reset == 1'b1);
    rd_a_q <= rd_addr;
  end
  always @(negedge clk) begin
    if (rd_v) begin
      check("n_rd", n_rd, mdl_n[rd_a_q]);
      check("m_rd", m_rd, mdl_m[rd_a_q]);
      check("e_rd", e_rd, mdl_e[rd_a_q]);
    end
  end

  task automatic set_stim(input int seed);
    for (int i = 0; i < 64; i++) begin
      s_n[i] = {32'(i * 7 + seed) * 32'h9E3779B9, ~32'(i + seed * 97)};
      s_m[i] = {32'(i + seed) ^ 32'hC3C3_5A5A, 32'(i * 13 + seed) * 32'h0101_0107};
      s_e[i] = {32'h1357_9BDF ^ 32'(i + seed), 32'(i + 1) * 32'h0102_0304};
    end
  endtask

  task automatic zero_fill(input int nw);
    if (FILL_EN) begin
      for (int i = nw; i < 64; i++) begin
        mdl_n[i] = '0;
        mdl_m[i] = '0;
        mdl_e[i] = '0;
      end
    end
  endtask

  // Streams nw words; returns the cycle count seen at the negedge after the last accept.
  task automatic do_load(input int nw, input bit last_flag, output int acc);
    chk_rd = 1'b0;
    @(posedge clk);
    for (int i = 0; i < nw; i++) begin
      @(negedge clk);
      chk_bit("in_ready_load", in_ready, 1'b1);
      in_valid = 1'b1;
      n_in     = s_n[i];
      m_in     = s_m[i];
      e_in     = s_e[i];
      in_last  = last_flag && (i == nw - 1);
      mdl_n[i] = s_n[i];
      mdl_m[i] = s_m[i];
      mdl_e[i] = s_e[i];
    end
    @(negedge clk);
    acc      = cyc;
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (last_flag || nw == 64) zero_fill(nw);
  endtask

  task automatic wait_start(input int acc, input int exp_lat, input int exp_wc, input string tag);
    int t;
    t = 0;
    while (core_start !== 1'b1 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (core_start !== 1'b1) begin
      chk_bit({tag, "_start_seen"}, core_start, 1'b1);
    end else begin
      check({tag, "_latency"}, 64'(cyc - acc + 1), 64'(exp_lat));
      check({tag, "_word_count"}, 64'(word_count), 64'(exp_wc));
      check({tag, "_e_bits"}, 64'(e_bits), 64'(exp_bits(exp_wc)));
      chk_bit({tag, "_in_ready_start"}, in_ready, 1'b0);
      chk_bit({tag, "_busy_start"}, busy, 1'b1);
      @(negedge clk);
      chk_bit({tag, "_start_width"}, core_start, 1'b0);
      chk_bit({tag, "_busy_wait"}, busy, 1'b1);
      chk_bit({tag, "_in_ready_wait"}, in_ready, 1'b0);
    end
  endtask

  task automatic sweep();
    chk_rd = 1'b1;
    for (int a = 0; a < 64; a++) begin
      rd_addr = 6'(a);
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic done_pulse(input string tag);
    @(negedge clk);
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
    chk_bit({tag, "_done_in_ready"}, in_ready, 1'b1);
    chk_bit({tag, "_done_busy"}, busy, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int cnt_err;
    int cnt_st;

    reset = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    n_in = '0; m_in = '0; e_in = '0; core_done = 1'b0; rd_addr = '0;
    for (int i = 0; i < 64; i++) begin
      mdl_n[i] = '0; mdl_m[i] = '0; mdl_e[i] = '0;
    end

    // Reset values.
    #2;
    chk_bit("rst_in_ready", in_ready, 1'b1);
    chk_bit("rst_busy", busy, 1'b0);
    chk_bit("rst_core_start", core_start, 1'b0);
    chk_bit("rst_err", err_zero_exp, 1'b0);
    check("rst_word_count", 64'(word_count), 64'd0);
    check("rst_e_bits", 64'(e_bits), 64'd0);
    check("rst_n_rd", n_rd, 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // 64 words, in_last never set: ends on word 63, no fill.
    set_stim(1);
    for (int i = 39; i < 64; i++) s_e[i] = '0;
    s_e[39] = 64'h0000_0000_0001_0000;
    do_load(64, 1'b0, acc);
    wait_start(acc, 1, 64, "full");
    check("full_e_bits_lit", 64'(e_bits), 64'd2513);
    sweep();
    done_pulse("full");

    // Single word.
    s_n[0] = 64'hEAA06C6A1B82DFBB;
    s_m[0] = 64'h5B32DD707D25FCB0;
    s_e[0] = 64'h6E74641191D3CDF1;
    do_load(1, 1'b1, acc);
    wait_start(acc, lat(1), 1, "single");
    check("single_e_bits_lit", 64'(e_bits), 64'd63);
    check("single_wc_lit", 64'(word_count), 64'd1);
    rd_addr = 6'd0;
    @(negedge clk);
    check("single_n_rd_lit", n_rd, 64'hEAA06C6A1B82DFBB);
    check("single_m_rd_lit", m_rd, 64'h5B32DD707D25FCB0);
    check("single_e_rd_lit", e_rd, 64'h6E74641191D3CDF1);
    sweep();
    done_pulse("single");

    // Sixteen words.
    set_stim(2);
    s_e[15] = 64'h0B738D2595E4CD4B;
    do_load(16, 1'b1, acc);
    wait_start(acc, lat(16), 16, "sixteen");
    check("sixteen_e_bits_lit", 64'(e_bits), 64'd1020);
    check("sixteen_wc_lit", 64'(word_count), 64'd16);
    sweep();

    // Held input during WAIT is ignored; after core_done a new load starts at 0.
    chk_rd = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk_bit("hold_in_ready", in_ready, 1'b0);
      in_valid = 1'b1;
      n_in = 64'hA1A1_0000_0000_0001;
      m_in = 64'hB2B2_0000_0000_0002;
      e_in = 64'h0000_0000_0000_0005;
      in_last = 1'b1;
    end
    @(negedge clk);
    chk_bit("hold_busy", busy, 1'b1);
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
    chk_bit("after_done_in_ready", in_ready, 1'b1);
    chk_bit("after_done_busy", busy, 1'b0);
    mdl_n[0] = 64'hA1A1_0000_0000_0001;
    mdl_m[0] = 64'hB2B2_0000_0000_0002;
    mdl_e[0] = 64'h0000_0000_0000_0005;
    @(negedge clk);
    acc = cyc;
    in_valid = 1'b0;
    in_last  = 1'b0;
    zero_fill(1);
    wait_start(acc, lat(1), 1, "reload");
    check("reload_e_bits_lit", 64'(e_bits), 64'd3);
    sweep();
    done_pulse("reload");

    // All-zero exponent.
    set_stim(3);
    for (int i = 0; i < 64; i++) s_e[i] = '0;
    do_load(4, 1'b1, acc);
    cnt_err = 0;
    cnt_st  = 0;
    for (int t = 0; t < 100; t++) begin
      if (err_zero_exp === 1'b1) cnt_err++;
      if (core_start === 1'b1) cnt_st++;
      @(negedge clk);
    end
    check("zero_err_pulses", 64'(cnt_err), 64'd1);
    check("zero_start_pulses", 64'(cnt_st), 64'd0);
    chk_bit("zero_in_ready", in_ready, 1'b1);
    chk_bit("zero_busy", busy, 1'b0);
    check("zero_e_bits", 64'(e_bits), 64'd0);
    check("zero_word_count", 64'(word_count), 64'd4);

    // Reset in the middle of a load.
    set_stim(4);
    rd_addr = 6'd3;
    do_load(6, 1'b0, acc);
    chk_bit("midload_busy", busy, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    chk_bit("midrst_in_ready", in_ready, 1'b1);
    chk_bit("midrst_busy", busy, 1'b0);
    chk_bit("midrst_core_start", core_start, 1'b0);
    chk_bit("midrst_err", err_zero_exp, 1'b0);
    check("midrst_word_count", 64'(word_count), 64'd0);
    check("midrst_e_bits", 64'(e_bits), 64'd0);
    check("midrst_n_rd", n_rd, 64'd0);
    check("midrst_m_rd", m_rd, 64'd0);
    check("midrst_e_rd", e_rd, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    set_stim(5);
    do_load(2, 1'b1, acc);
    wait_start(acc, lat(2), 2, "postrst");
    sweep();
    done_pulse("postrst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
